// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
// A request stays up with a stable address until the memory answers with I_ACK.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               I_REQ;
  logic [ADDR_W-1:0]  I_ADDR;
  logic               I_ACK;
  logic [INSTR_W-1:0] I_RDATA;

  modport master (output I_REQ, output I_ADDR, input I_ACK, input I_RDATA);
  modport slave  (input I_REQ, input I_ADDR, output I_ACK, output I_RDATA);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, prefetches the word at PC into a one-entry buffer
// and loads the IR from it on request of the control unit.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   PC_CLR,
  input  logic                   PC_IC,
  input  logic                   IR_LD,
  instruction_fetch_unit_if.master imem,
  output logic [ADDR_W-1:0]      PC,
  output logic [INSTR_W-1:0]     IR,
  output logic                   IR_VALID,
  output logic                   IF_READY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] fbuf;
  logic               pc_chg;

  always_comb begin
    pc_chg  = PC_CLR | PC_IC;
    pc_next = PC;
    if (PC_CLR)
      pc_next = RESET_PC;
    else if (PC_IC)
      pc_next = PC + PC_ONE;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= S_IDLE;
      PC       <= RESET_PC;
      req_addr <= RESET_PC;
      fbuf     <= '0;
      IR       <= '0;
      IR_VALID <= 1'b0;
    end else begin
      PC <= pc_next;

      // IR takes the buffered word at the old PC, even when PC_IC moves it this cycle
      if (PC_CLR) begin
        IR       <= '0;
        IR_VALID <= 1'b0;
      end else if (IR_LD && state == S_FULL) begin
        IR       <= fbuf;
        IR_VALID <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          req_addr <= pc_next;
        end
        S_REQ: begin
          // A request is never withdrawn; a stale answer only triggers a re-issue
          if (imem.I_ACK) begin
            if (!pc_chg && req_addr == PC) begin
              fbuf  <= imem.I_RDATA;
              state <= S_FULL;
            end else begin
              req_addr <= pc_next;
            end
          end
        end
        S_FULL: begin
          if (pc_chg) begin
            state    <= S_REQ;
            req_addr <= pc_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem.I_REQ  = (state == S_REQ);
  assign imem.I_ADDR = req_addr;
  assign IF_READY    = (state == S_FULL);

endmodule
